varredura_matriz: RTL

VARREDURA_MATRIZ -- requirements
Module: varredura_matriz

---
 rtl/varredura_matriz_if.sv | 28 ++
 rtl/varredura_matriz.sv | 114 +++++++++++
 2 files changed

// File: rtl/varredura_matriz_if.sv
// rtl/varredura_matriz_if.sv - control/row-drive bundle for the 7-row matrix scanner
//
// Signals:
//   pausa       level, 1 freezes automatic frame advance
//   avanca      asynchronous push-button, manual frame step while paused
//   contador    current row index 0..6
//   quadros     current frame index 0..7
//   linhas      active-low one-hot row drive
//   tick_linha  one-cycle pulse in the first cycle of each new row
// Modports: master drives pausa/avanca and observes the rest; slave is the scanner.
interface varredura_matriz_if;
    logic       pausa;
    logic       avanca;
    logic [2:0] contador;
    logic [2:0] quadros;
    logic [6:0] linhas;
    logic       tick_linha;

    modport master (
        output pausa, avanca,
        input  contador, quadros, linhas, tick_linha
    );

    modport slave (
        input  pausa, avanca,
        output contador, quadros, linhas, tick_linha
    );
endinterface

// File: rtl/varredura_matriz.sv
// rtl/varredura_matriz.sv - 7-row LED matrix scanner with auto/manual frame sequencing
//
// Ports:
//   clk    system clock, all state on rising edge
//   rst_n  asynchronous active-low reset
//   bus    varredura_matriz_if.slave (pausa, avanca in; contador, quadros, linhas, tick_linha out)
// Parameters:
//   DIV              clock cycles per row period (2..2^20)
//   SCANS_PER_FRAME  full 7-row scans per frame in auto mode (1..256)
// Build option:
//   VARREDURA_BLANKING_EN  when defined, linhas is blanked (7'h7F) for the cycle
//                          tick_linha is high, then shows the new row.
module varredura_matriz #(
    parameter int DIV             = 50000,
    parameter int SCANS_PER_FRAME = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    varredura_matriz_if.slave bus
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int SW = $clog2(SCANS_PER_FRAME + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [SW-1:0] SCAN_TOP = SW'(SCANS_PER_FRAME);

    logic [PW-1:0] prescaler;
    logic [2:0]    contador_q;
    logic [2:0]    quadros_q;
    logic [6:0]    linhas_q;
    logic          tick_q;
    logic [SW-1:0] scans;
    logic          sync1;
    logic          sync2;
    logic          edge_q;

    logic          row_tick;
    logic          scan_wrap;
    logic          step;
    logic [2:0]    contador_next;
    logic [SW-1:0] scans_inc;

    function automatic logic [6:0] row_drive(input logic [2:0] r);
        return ~(7'b1 << r);
    endfunction

    always_comb begin
        row_tick      = (prescaler == PRE_LAST);
        scan_wrap     = row_tick && (contador_q == 3'd6);
        // sync2 is the synchronized level, edge_q its previous value
        step          = sync2 & ~edge_q;
        contador_next = (contador_q == 3'd6) ? 3'd0 : contador_q + 3'd1;
        scans_inc     = scans + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            contador_q <= 3'd0;
            quadros_q  <= 3'd0;
            linhas_q   <= 7'h7E;
            tick_q     <= 1'b0;
            scans      <= '0;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            sync1  <= bus.avanca;
            sync2  <= sync1;
            edge_q <= sync2;
            tick_q <= row_tick;

            if (row_tick) begin
                prescaler  <= '0;
                contador_q <= contador_next;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

`ifdef VARREDURA_BLANKING_EN
            // Blank on the tick edge, then decode the already-updated row.
            if (row_tick) begin
                linhas_q <= 7'h7F;
            end else begin
                linhas_q <= row_drive(contador_q);
            end
`else
            if (row_tick) begin
                linhas_q <= row_drive(contador_next);
            end
`endif

            // Paused: scan count parked at 0 so auto mode restarts a full frame
            // on resume; manual steps win over any coinciding scan wrap.
            if (bus.pausa) begin
                scans <= '0;
                if (step) begin
                    quadros_q <= quadros_q + 3'd1;
                end
            end else if (scan_wrap) begin
                if (scans_inc == SCAN_TOP) begin
                    scans     <= '0;
                    quadros_q <= quadros_q + 3'd1;
                end else begin
                    scans <= scans_inc;
                end
            end
        end
    end

    assign bus.contador   = contador_q;
    assign bus.quadros    = quadros_q;
    assign bus.linhas     = linhas_q;
    assign bus.tick_linha = tick_q;
endmodule
